// File: rtl/cpu_pkg.sv
// cpu_pkg: shared FSM state encoding, opcode constants and the instruction legality check
// used by the CPU control unit.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_FETCH_WAIT,
        ST_DECODE,
        ST_READ_WAIT,
        ST_EXEC,
        ST_DIV_WAIT,
        ST_WRITE,
        ST_HALT
    } state_t;

    localparam logic [3:0] OP_LOAD  = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_SUB   = 4'b0010;
    localparam logic [3:0] OP_MUL   = 4'b0011;
    localparam logic [3:0] OP_DIV   = 4'b0100;
    localparam logic [3:0] OP_STORE = 4'b1111;

    localparam logic [3:0]  INSN_PREFIX = 4'b0001;
    localparam logic [15:0] INSN_HALT   = 16'h0000;

    // The halt word is not "legal" here; the decoder tells it apart so it does not raise ERR.
    function automatic logic insn_legal(input logic [15:0] insn, input logic div_en);
        logic ok;
        ok = 1'b0;
        if (insn[15:12] == INSN_PREFIX) begin
            case (insn[11:8])
                OP_LOAD, OP_ADD, OP_SUB, OP_MUL, OP_STORE: ok = 1'b1;
                OP_DIV:                                    ok = div_en;
                default:                                   ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

endpackage

// File: rtl/cpu_divider.sv
// cpu_divider: 16-step restoring unsigned divider with a start/done handshake.
// done pulses for one cycle; a zero divisor returns all-ones and raises div_by_zero.
module cpu_divider #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic         div_by_zero
);
    localparam int CW = $clog2(W + 1);

    logic          busy;
    logic [CW-1:0] count;
    logic [W-1:0]  rem;
    logic [W-1:0]  quo;
    logic [W-1:0]  dvs;
    logic          dz;
    logic [W:0]    shifted;
    logic [W:0]    diff;

    // One restoring step: shift the next dividend bit in, subtract if it does not borrow.
    always_comb begin
        shifted = {rem, quo[W-1]};
        diff    = shifted - {1'b0, dvs};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy  <= 1'b0;
            count <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                busy  <= 1'b1;
                count <= CW'(W);
            end else if (busy) begin
                count <= count - 1'b1;
                if (count == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    // NOTE: datapath registers carry no reset; they are loaded by start before any result is used.
    always_ff @(posedge clk) begin
        if (start) begin
            rem <= '0;
            quo <= dividend;
            dvs <= divisor;
            dz  <= (divisor == '0);
        end else if (busy) begin
            rem <= diff[W] ? shifted[W-1:0] : diff[W-1:0];
            quo <= {quo[W-2:0], ~diff[W]};
        end
    end

    assign quotient    = dz ? '1 : quo;
    assign div_by_zero = dz;

endmodule

// File: rtl/cpu_control_unit.sv
// cpu_control_unit: fetch/decode/execute sequencer driving the 256x16 CPU memory.
// Define CPU_DIV_EN to execute DIV on cpu_divider; without it DIV decodes as illegal.
module cpu_control_unit
    import cpu_pkg::*;
#(
    parameter int PC_START = 100,
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 8
) (
    input  logic              CLK,
    input  logic              RST,
    output logic [DATA_W-1:0] MAR,
    input  logic [DATA_W-1:0] OUT_MEMORY,
    output logic [ADDR_W-1:0] ADDRESS,
    input  logic [DATA_W-1:0] OUT_ADDRESS_MEMORY,
    output logic [DATA_W-1:0] IN_ADDRESS_MEMORY,
    output logic              WE,
    output logic [ADDR_W-1:0] PC,
    output logic [DATA_W-1:0] AR,
    output logic              BUSY,
    output logic              HALTED,
    output logic              ERR
);
    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] opnd;
    logic [3:0]        op;
    logic              legal;
    logic              is_halt;
    logic              div_start;
    logic              div_done;
    logic              div_by_zero;
    logic [DATA_W-1:0] quotient;

`ifdef CPU_DIV_EN
    localparam logic DIV_EN = 1'b1;

    cpu_divider #(
        .W (DATA_W)
    ) u_divider (
        .clk         (CLK),
        .rst         (RST),
        .start       (div_start),
        .dividend    (AR),
        .divisor     (opnd),
        .done        (div_done),
        .quotient    (quotient),
        .div_by_zero (div_by_zero)
    );
`else
    localparam logic DIV_EN = 1'b0;

    logic div_start_unused;
    assign div_start_unused = div_start;
    assign div_done         = 1'b0;
    assign div_by_zero      = 1'b0;
    assign quotient         = '0;
`endif

    assign op      = ir[11:8];
    assign legal   = insn_legal(ir, DIV_EN);
    assign is_halt = (ir == INSN_HALT);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) state <= ST_FETCH;
        else     state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        div_start  = 1'b0;
        case (state)
            ST_FETCH:      state_next = ST_FETCH_WAIT;
            ST_FETCH_WAIT: state_next = ST_DECODE;
            ST_DECODE: begin
                if (!legal)                state_next = ST_HALT;
                else if (op == OP_STORE)   state_next = ST_WRITE;
                else                       state_next = ST_READ_WAIT;
            end
            ST_READ_WAIT:  state_next = ST_EXEC;
            ST_EXEC: begin
                if (op == OP_DIV && DIV_EN) begin
                    div_start  = 1'b1;
                    state_next = ST_DIV_WAIT;
                end else begin
                    state_next = ST_FETCH;
                end
            end
            ST_DIV_WAIT: begin
                if (div_done) state_next = ST_FETCH;
            end
            ST_WRITE:      state_next = ST_FETCH;
            ST_HALT:       state_next = ST_HALT;
            default:       state_next = ST_FETCH;
        endcase
    end

    // Architectural registers; RST during any state discards the instruction in flight.
    always_ff @(posedge CLK) begin
        if (RST) begin
            PC                <= ADDR_W'(PC_START);
            MAR               <= DATA_W'(PC_START);
            ADDRESS           <= '0;
            IN_ADDRESS_MEMORY <= '0;
            AR                <= '0;
            ERR               <= 1'b0;
        end else begin
            case (state)
                ST_FETCH:      MAR <= {{(DATA_W-ADDR_W){1'b0}}, PC};
                ST_FETCH_WAIT: PC  <= PC + 1'b1;
                ST_DECODE: begin
                    if (!legal) begin
                        if (!is_halt) ERR <= 1'b1;
                    end else begin
                        ADDRESS <= ir[ADDR_W-1:0];
                        if (op == OP_STORE) IN_ADDRESS_MEMORY <= AR;
                    end
                end
                ST_EXEC: begin
                    case (op)
                        OP_LOAD: AR <= opnd;
                        OP_ADD:  AR <= AR + opnd;
                        OP_SUB:  AR <= AR - opnd;
                        OP_MUL:  AR <= AR * opnd;
                        default: AR <= AR;
                    endcase
                end
                ST_DIV_WAIT: begin
                    if (div_done) begin
                        AR <= quotient;
                        if (div_by_zero) ERR <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ir and opnd are always written before they are consumed, so they stay out of reset.
    always_ff @(posedge CLK) begin
        if (state == ST_FETCH_WAIT) ir   <= OUT_MEMORY;
        if (state == ST_READ_WAIT)  opnd <= OUT_ADDRESS_MEMORY;
    end

    // The write strobe is masked by RST so an aborted store never reaches memory.
    assign WE     = (state == ST_WRITE) && !RST;
    assign BUSY   = (state != ST_HALT);
    assign HALTED = (state == ST_HALT);

endmodule

// File: tb/tb_cpu_control_unit.sv
// tb_cpu_control_unit: drives the control unit against a combinational-read memory and checks
// results against an instruction-level reference interpreter. Honours CPU_DIV_EN like the RTL.
module tb_cpu_control_unit;
    localparam int PC0    = 100;
    localparam int MAXCYC = 4000;
`ifdef CPU_DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] mar;
    logic [15:0] out_memory;
    logic [7:0]  address;
    logic [15:0] out_address_memory;
    logic [15:0] in_address_memory;
    logic        we;
    logic [7:0]  pc;
    logic [15:0] ar;
    logic        busy;
    logic        halted;
    logic        err;

    logic [15:0] mem      [256];
    logic [15:0] init_mem [256];
    logic [15:0] exp_mem  [256];
    logic [15:0] ar_trace [MAXCYC+1];
    logic        load_req = 1'b0;
    int          we_count = 0;
    logic [7:0]  last_we_addr = 8'h00;

    int          n_checks = 0;
    int          n_pass   = 0;

    logic [15:0] exp_ar;
    logic [7:0]  exp_pc;
    logic        exp_err;
    int          exp_cycles;
    int          exp_we;

    cpu_control_unit #(
        .PC_START (PC0),
        .DATA_W   (16),
        .ADDR_W   (8)
    ) dut (
        .CLK                (clk),
        .RST                (rst),
        .MAR                (mar),
        .OUT_MEMORY         (out_memory),
        .ADDRESS            (address),
        .OUT_ADDRESS_MEMORY (out_address_memory),
        .IN_ADDRESS_MEMORY  (in_address_memory),
        .WE                 (we),
        .PC                 (pc),
        .AR                 (ar),
        .BUSY               (busy),
        .HALTED             (halted),
        .ERR                (err)
    );

    always #5 clk = ~clk;

    assign out_memory         = mem[mar[7:0]];
    assign out_address_memory = mem[address];

    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_mem[i];
        end else if (we) begin
            mem[address] <= in_address_memory;
        end
    end

    always @(negedge clk) begin
        if (we) begin
            we_count     <= we_count + 1;
            last_we_addr <= address;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) init_mem[i] = 16'h0000;
    endtask

    // Instruction-level interpreter: architectural effect plus documented cycle cost per opcode.
    task automatic model_run();
        logic [7:0]  mpc;
        logic [15:0] w;
        logic [15:0] v;
        logic [3:0]  op;
        bit          legal;
        exp_ar = 16'h0000; exp_err = 1'b0; exp_cycles = 0; exp_we = 0; mpc = 8'(PC0);
        for (int i = 0; i < 256; i++) exp_mem[i] = init_mem[i];
        for (int n = 0; n < 1000; n++) begin
            w   = exp_mem[mpc];
            mpc = mpc + 8'd1;
            op  = w[11:8];
            v   = exp_mem[w[7:0]];
            legal = (w[15:12] == 4'h1) &&
                    ((op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'hF}) || (op == 4'h4 && DIV_ON));
            if (!legal) begin
                exp_cycles += 3;
                if (w != 16'h0000) exp_err = 1'b1;
                break;
            end
            case (op)
                4'h0: begin exp_ar = v;          exp_cycles += 5; end
                4'h1: begin exp_ar = exp_ar + v; exp_cycles += 5; end
                4'h2: begin exp_ar = exp_ar - v; exp_cycles += 5; end
                4'h3: begin exp_ar = exp_ar * v; exp_cycles += 5; end
                4'h4: begin
                    if (v == 16'h0000) begin exp_ar = 16'hFFFF; exp_err = 1'b1; end
                    else exp_ar = exp_ar / v;
                    exp_cycles += 22;
                end
                default: begin exp_mem[w[7:0]] = exp_ar; exp_we++; exp_cycles += 4; end
            endcase
        end
        exp_pc = mpc;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; load_req = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pc", pc, PC0);
        check("rst_mar", mar, PC0);
        check("rst_address", address, 0);
        check("rst_wdata", in_address_memory, 0);
        check("rst_we", we, 0);
        check("rst_ar", ar, 0);
        check("rst_halted", halted, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 1);
        @(negedge clk);
        rst = 1'b0; load_req = 1'b0;
    endtask

    task automatic run_program(input string tag);
        int cyc;
        int we_base;
        bit done;
        model_run();
        do_reset();
        we_base = we_count;
        cyc = 0; done = 1'b0;
        while (!done && cyc < MAXCYC) begin
            @(posedge clk); #1;
            cyc++;
            ar_trace[cyc] = ar;
            if (halted) done = 1'b1;
        end
        check($sformatf("%s_halted", tag), halted, 1);
        check($sformatf("%s_cycles", tag), cyc, exp_cycles);
        check($sformatf("%s_pc", tag), pc, exp_pc);
        check($sformatf("%s_ar", tag), ar, exp_ar);
        check($sformatf("%s_err", tag), err, exp_err);
        check($sformatf("%s_busy", tag), busy, 0);
        check($sformatf("%s_mar_hi", tag), mar[15:8], 0);
        check($sformatf("%s_we_count", tag), we_count - we_base, exp_we);
        repeat (3) @(posedge clk);
        #1;
        check($sformatf("%s_hold_ar", tag), ar, exp_ar);
        check($sformatf("%s_hold_pc", tag), pc, exp_pc);
        check($sformatf("%s_hold_we", tag), we, 0);
        for (int i = 0; i < 256; i++)
            check($sformatf("%s_mem%0d", tag, i), mem[i], exp_mem[i]);
    endtask

    initial begin
        int          len;
        int          pick;
        int          we_base;
        logic [3:0]  rop;
        logic [15:0] rdata;

        // Basic add-and-store program.
        clear_mem();
        init_mem[1] = 16'd1; init_mem[2] = 16'd2;
        init_mem[100] = 16'h1001; init_mem[101] = 16'h1102;
        init_mem[102] = 16'h1F07; init_mem[103] = 16'h0000;
        run_program("add_store");
        check("add_store_mem7", mem[7], 16'd3);
        check("add_store_pc104", pc, 8'd104);
        check("add_store_we_addr", last_we_addr, 8'd7);

        // Subtraction and wrap below zero.
        clear_mem();
        init_mem[3] = 16'd128; init_mem[4] = 16'd64;
        init_mem[100] = 16'h1003; init_mem[101] = 16'h1204;
        init_mem[102] = 16'h1F08; init_mem[103] = 16'h1203;
        run_program("sub_wrap");
        check("sub_wrap_mem8", mem[8], 16'd64);
        check("sub_wrap_ar", ar, 16'hFFC0);

        // Multiply, including truncation to 16 bits.
        clear_mem();
        init_mem[5] = 16'd12; init_mem[2] = 16'd2; init_mem[10] = 16'hFFFF;
        init_mem[100] = 16'h1005; init_mem[101] = 16'h1302;
        init_mem[102] = 16'h1F09; init_mem[103] = 16'h100A;
        init_mem[104] = 16'h1302;
        run_program("mul");
        check("mul_mem9", mem[9], 16'd24);
        check("mul_ar_trunc", ar, 16'hFFFE);

        // Divide (or illegal opcode when the divider is not built).
        clear_mem();
        init_mem[6] = 16'd3072; init_mem[2] = 16'd2;
        init_mem[100] = 16'h1006; init_mem[101] = 16'h1402;
        run_program("div");
        if (DIV_ON) begin
            check("div_ar_before", ar_trace[26], 16'd3072);
            check("div_ar_at_22", ar_trace[27], 16'd1536);
        end else begin
            check("nodiv_err", err, 1);
            check("nodiv_pc", pc, 8'd102);
        end

        // Divide by zero keeps executing.
        clear_mem();
        init_mem[6] = 16'd3072;
        init_mem[100] = 16'h1006; init_mem[101] = 16'h1400;
        init_mem[102] = 16'h1F0B; init_mem[103] = 16'h1006;
        run_program("div0");

        // Illegal opcode at the start address.
        clear_mem();
        init_mem[100] = 16'h1500;
        run_program("illegal");
        check("illegal_err", err, 1);
        check("illegal_pc", pc, 8'd101);

        // Reset asserted while the store strobe is up.
        clear_mem();
        init_mem[1] = 16'h0055; init_mem[10] = 16'h1234;
        init_mem[100] = 16'h1001; init_mem[101] = 16'h1F0A;
        do_reset();
        we_base = we_count;
        repeat (8) @(posedge clk);
        #1;
        check("rw_we_in_write", we, 1);
        check("rw_address", address, 8'd10);
        check("rw_wdata", in_address_memory, 16'h0055);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rw_pc", pc, PC0);
        check("rw_ar", ar, 0);
        check("rw_we", we, 0);
        check("rw_mar", mar, PC0);
        @(negedge clk);
        check("rw_no_write", mem[10], 16'h1234);
        check("rw_we_pulses", we_count - we_base, 0);
        rst = 1'b0;
        run_program("after_rw");

        // Reset asserted mid-divide.
        if (DIV_ON) begin
            clear_mem();
            init_mem[6] = 16'd3072; init_mem[2] = 16'd2;
            init_mem[100] = 16'h1006; init_mem[101] = 16'h1402;
            do_reset();
            repeat (15) @(posedge clk);
            #1;
            check("rd_busy_mid", busy, 1);
            rst = 1'b1;
            @(posedge clk); #1;
            check("rd_pc", pc, PC0);
            check("rd_ar", ar, 0);
            check("rd_we", we, 0);
            check("rd_err", err, 0);
            rst = 1'b0;
            run_program("after_rd");
        end

        // PC wraps from 255 to 0.
        clear_mem();
        init_mem[1] = 16'd5; init_mem[2] = 16'd7;
        for (int a = 100; a < 255; a++) init_mem[a] = 16'h1001;
        init_mem[255] = 16'h1102;
        run_program("pc_wrap");
        check("pc_wrap_pc", pc, 8'd1);
        check("pc_wrap_ar", ar, 16'd12);

        // Random programs over a 64-word data region.
        for (int r = 0; r < 6; r++) begin
            clear_mem();
            for (int a = 0; a < 64; a++) begin
                rdata = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 5)) : 16'($urandom);
                init_mem[a] = rdata;
            end
            len = $urandom_range(8, 16);
            for (int k = 0; k < len; k++) begin
                pick = $urandom_range(0, DIV_ON ? 5 : 4);
                case (pick)
                    0:       rop = 4'h0;
                    1:       rop = 4'h1;
                    2:       rop = 4'h2;
                    3:       rop = 4'h3;
                    4:       rop = 4'hF;
                    default: rop = 4'h4;
                endcase
                init_mem[100 + k] = {4'h1, rop, 8'($urandom_range(0, 63))};
            end
            if (r == 5) init_mem[100 + len / 2] = 16'h1700;
            run_program($sformatf("rand%0d", r));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
